// File: rtl/multi_debounce.sv
// -----------------------------------------------------------------------------
// multi_debounce
//
// Purpose
//   N-channel push-button / switch debouncer for raw board inputs. Each
//   channel has the same independent pipeline:
//     - a two-flop synchroniser for the asynchronous pad input
//     - a stable-window counter. The debounced level flips only after the
//       synchronised input has differed from it for STABLE_CYCLES
//       consecutive cycles.
//     - registered one-cycle press / release event pulses
//     - optional hold-to-auto-repeat pulses while the level stays high
//
// Parameters
//   CHANNELS       number of independent input channels (>=1)
//   STABLE_CYCLES  cycles the synchronised input must disagree with the
//                  level before the level flips (>=1)
//   REPEAT_EN      1 = generate auto-repeat pulses, 0 = rpt tied low
//   REPEAT_DELAY   cycles from the press pulse to the first repeat (>=1)
//   REPEAT_PERIOD  cycles between later repeat pulses (>=1)
//
// Ports
//   Clk     in   1         system clock; all state changes on the rising edge
//   Rst_n   in   1         asynchronous active-low reset
//   but     in   CHANNELS  raw asynchronous button inputs, active high
//   level   out  CHANNELS  debounced registered level
//   press   out  CHANNELS  1-cycle pulse on a debounced rising edge
//   rel     out  CHANNELS  1-cycle pulse on a debounced falling edge
//                          (the release event; "release" is a reserved word)
//   rpt     out  CHANNELS  1-cycle auto-repeat pulse
// -----------------------------------------------------------------------------
module multi_debounce #(
   parameter int CHANNELS      = 4,
   parameter int STABLE_CYCLES = 4194303,
   parameter int REPEAT_EN     = 0,
   parameter int REPEAT_DELAY  = 50000000,
   parameter int REPEAT_PERIOD = 10000000
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic [CHANNELS-1:0] but,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] press,
   output logic [CHANNELS-1:0] rel,
   output logic [CHANNELS-1:0] rpt
);

   // Stable-window counter. It only has to reach STABLE_CYCLES-1, so
   // $clog2 bits are enough. Keep at least one bit for STABLE_CYCLES=1.
   localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   genvar gi;

   for (gi = 0; gi < CHANNELS; gi++) begin : g_ch

      logic          s1_reg;
      logic          s2_reg;
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          level_reg;
      logic          level_next;
      logic          press_reg;
      logic          press_next;
      logic          rel_reg;
      logic          rel_next;
      logic          flip;

      // -----------------------------------------------------------------
      // State registers. Reset is asynchronous, so a debounce that is in
      // progress is dropped at once and no pulse is issued for it.
      // -----------------------------------------------------------------
      always_ff @(posedge Clk or negedge Rst_n) begin
         if (!Rst_n) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            rel_reg   <= 1'b0;
         end else begin
            s1_reg    <= but[gi];
            s2_reg    <= s1_reg;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            press_reg <= press_next;
            rel_reg   <= rel_next;
         end
      end

      // -----------------------------------------------------------------
      // Debounce. Any cycle where the synchronised input agrees with the
      // current level restarts the window. When the input has disagreed
      // for a full window, the level flips and the matching event pulse
      // fires for exactly one cycle. Because press and release both come
      // from the same flip, they can never be high together.
      // -----------------------------------------------------------------
      always_comb begin
         cnt_next   = '0;
         level_next = level_reg;
         press_next = 1'b0;
         rel_next   = 1'b0;
         flip       = 1'b0;
         if (s2_reg != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
               flip       = 1'b1;
               level_next = s2_reg;
               press_next = s2_reg;
               rel_next   = ~s2_reg;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
      end

      assign level[gi] = level_reg;
      assign press[gi] = press_reg;
      assign rel[gi]   = rel_reg;

      if (REPEAT_EN != 0) begin : g_rpt

         // One counter serves both the initial delay and the period.
         // It is sized for the larger of the two limits.
         localparam int RDW = (REPEAT_DELAY > 1)  ? $clog2(REPEAT_DELAY)  : 1;
         localparam int RPW = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
         localparam int RW  = (RDW > RPW) ? RDW : RPW;
         localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
         localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

         logic [RW-1:0] rcnt_reg;
         logic [RW-1:0] rcnt_next;
         logic [RW-1:0] rlimit;
         logic          repeated_reg;   // first repeat already issued
         logic          repeated_next;
         logic          rpt_reg;
         logic          rpt_next;

         always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
               rcnt_reg     <= '0;
               repeated_reg <= 1'b0;
               rpt_reg      <= 1'b0;
            end else begin
               rcnt_reg     <= rcnt_next;
               repeated_reg <= repeated_next;
               rpt_reg      <= rpt_next;
            end
         end

         // A level flip in either direction restarts the repeat timing.
         // On the press edge this arms the initial delay. On the release
         // edge it suppresses a repeat that would otherwise have landed
         // in the same cycle. Because the flip has priority, rpt never
         // coincides with press.
         always_comb begin
            rcnt_next     = '0;
            repeated_next = repeated_reg;
            rpt_next      = 1'b0;
            rlimit        = repeated_reg ? PER_LAST : DLY_LAST;
            if (flip) begin
               repeated_next = 1'b0;
            end else if (level_reg) begin
               if (rcnt_reg == rlimit) begin
                  rpt_next      = 1'b1;
                  repeated_next = 1'b1;
               end else begin
                  rcnt_next = rcnt_reg + RW'(1);
               end
            end
         end

         assign rpt[gi] = rpt_reg;

      end else begin : g_no_rpt

         assign rpt[gi] = 1'b0;

      end
   end

endmodule
